// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-ported register file:
// address-width calculation and write-port priority selection.
package regfile_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
   localparam int WP_MAX   = 32;

   function automatic int calc_aw(input int nreg);
      return (nreg > 1) ? $clog2(nreg) : 1;
   endfunction

   // Highest-index asserted hit wins; returns 0 when no bit is set.
   function automatic int wp_pick(input logic [WP_MAX-1:0] hit);
      int sel;
      sel = 0;
      for (int i = 0; i < WP_MAX; i++) begin
         if (hit[i]) sel = i;
      end
      return sel;
   endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// One read port: selects forwarded same-cycle write data or the stored
// value, and masks data/busy for disabled reads, x0 and reset.
module regfile_bypass_mux
   import regfile_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NWP    = 2,
   parameter int BYPASS = 1,
   parameter int AW     = 5
)(
   input  logic                 i_reset,
   input  logic                 i_re,
   input  logic [AW-1:0]        i_raddr,
   input  logic [NWP-1:0]       i_we,
   input  logic [NWP*AW-1:0]    i_waddr,
   input  logic [NWP*XLEN-1:0]  i_wdata,
   input  logic [XLEN-1:0]      i_stored_data,
   input  logic                 i_stored_busy,
   output logic [XLEN-1:0]      o_rdata,
   output logic                 o_rbusy
);

   logic [WP_MAX-1:0] w_hit;
   logic [XLEN-1:0]   w_fwd;
   logic              w_fwd_en;
   int                w_sel;

   always_comb begin
      w_hit = '0;
      for (int k = 0; k < NWP; k++) begin
         w_hit[k] = i_we[k] && (i_waddr[k*AW +: AW] == i_raddr) && (i_raddr != '0);
      end
      w_sel = wp_pick(w_hit);
      w_fwd = '0;
      for (int k = 0; k < NWP; k++) begin
         if (k == w_sel) w_fwd = i_wdata[k*XLEN +: XLEN];
      end
      w_fwd_en = (BYPASS != 0) && (|w_hit);
   end

   always_comb begin
      o_rdata = '0;
      o_rbusy = 1'b0;
      if (!i_reset && i_re && (i_raddr != '0)) begin
         if (w_fwd_en) begin
            o_rdata = w_fwd;
         end else begin
            o_rdata = i_stored_data;
            o_rbusy = i_stored_busy;
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported flip-flop register file with x0 hardwired to zero,
// optional write-to-read bypass and a pending-write busy scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREG   = NREG_DEF,
   parameter int NRP    = 2,
   parameter int NWP    = 2,
   parameter int BYPASS = 1,
   localparam int AW    = calc_aw(NREG)
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NWP-1:0]       we,
   input  logic [NWP*AW-1:0]    waddr,
   input  logic [NWP*XLEN-1:0]  wdata,
   input  logic [NRP-1:0]       re,
   input  logic [NRP*AW-1:0]    raddr,
   output logic [NRP*XLEN-1:0]  rdata,
   output logic [NRP-1:0]       rbusy,
   input  logic                 busy_set,
   input  logic [AW-1:0]        busy_addr,
   output logic [AW:0]          pend_cnt,
   output logic                 idle
);

   logic [XLEN-1:0] r_regs [NREG];
   logic [NREG-1:0] r_busy;
   logic [AW:0]     r_pend_cnt;
   logic            r_idle;

   logic [NREG-1:0] w_wr_hit;
   logic [XLEN-1:0] w_wr_data [NREG];
   logic [NREG-1:0] w_busy_nxt;
   logic            w_set_ok;
   logic            w_inc;
   logic [AW:0]     w_dec;
   logic [AW:0]     w_cnt_nxt;

   // Per-register write decode; the highest-index enabled port wins.
   always_comb begin : wr_decode
      logic [WP_MAX-1:0] hv;
      int                sel;
      for (int n = 0; n < NREG; n++) begin
         hv = '0;
         for (int k = 0; k < NWP; k++) begin
            hv[k] = we[k] && (waddr[k*AW +: AW] == AW'(n)) && (n != 0);
         end
         sel          = wp_pick(hv);
         w_wr_hit[n]  = |hv;
         w_wr_data[n] = '0;
         for (int k = 0; k < NWP; k++) begin
            if (k == sel) w_wr_data[n] = wdata[k*XLEN +: XLEN];
         end
      end
   end

   assign w_set_ok = busy_set && (busy_addr != '0);

   // Set beats clear on the same register, so an issue that overlaps the
   // retiring write of the same destination keeps the bit pending.
   always_comb begin
      w_busy_nxt = r_busy;
      w_inc      = 1'b0;
      w_dec      = '0;
      for (int n = 0; n < NREG; n++) begin
         if (w_set_ok && (busy_addr == AW'(n))) w_busy_nxt[n] = 1'b1;
         else if (w_wr_hit[n])                  w_busy_nxt[n] = 1'b0;
      end
      for (int n = 0; n < NREG; n++) begin
         if (!r_busy[n] && w_busy_nxt[n]) w_inc = 1'b1;
         if (r_busy[n] && !w_busy_nxt[n]) w_dec = w_dec + (AW+1)'(1);
      end
      w_cnt_nxt = r_pend_cnt + (AW+1)'(w_inc) - w_dec;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int n = 0; n < NREG; n++) r_regs[n] <= '0;
         r_busy     <= '0;
         r_pend_cnt <= '0;
         r_idle     <= 1'b1;
      end else begin
         for (int n = 1; n < NREG; n++) begin
            if (w_wr_hit[n]) r_regs[n] <= w_wr_data[n];
         end
         r_busy     <= w_busy_nxt;
         r_pend_cnt <= w_cnt_nxt;
         r_idle     <= (w_cnt_nxt == '0);
      end
   end

   assign pend_cnt = r_pend_cnt;
   assign idle     = r_idle;

   for (genvar p = 0; p < NRP; p++) begin : g_rd
      logic [AW-1:0] w_ra;
      assign w_ra = raddr[p*AW +: AW];

      regfile_bypass_mux #(
         .XLEN   (XLEN),
         .NWP    (NWP),
         .BYPASS (BYPASS),
         .AW     (AW)
      ) u_mux (
         .i_reset       (reset),
         .i_re          (re[p]),
         .i_raddr       (w_ra),
         .i_we          (we),
         .i_waddr       (waddr),
         .i_wdata       (wdata),
         .i_stored_data (r_regs[w_ra]),
         .i_stored_busy (r_busy[w_ra]),
         .o_rdata       (rdata[p*XLEN +: XLEN]),
         .o_rbusy       (rbusy[p])
      );
   end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The parameters SHALL be as follows:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers (power of two, >=2).
- NRP, 2, number of read ports.
- NWP, 2, number of write ports.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = read returns the stored value only.
- AW, $clog2(NREG), address width (derived, not overridable).

REQ-002 The ports SHALL be as follows:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- we  in  NWP  per-write-port enable.
- waddr  in  NWP*AW  write addresses; port k occupies slice [k*AW +: AW].
- wdata  in  NWP*XLEN  write data; port k occupies slice [k*XLEN +: XLEN].
- re  in  NRP  per-read-port enable.
- raddr  in  NRP*AW  read addresses; port p occupies slice [p*AW +: AW].
- rdata  out  NRP*XLEN  read data.
- rbusy  out  NRP  read register still has a pending write.
- busy_set  in  1  at issue, mark busy_addr as pending.
- busy_addr  in  AW  destination register marked at issue.
- pend_cnt  out  AW+1  number of registers currently pending.
- idle  out  1  high when pend_cnt==0.

Function
REQ-003 Register 0 SHALL read as 0 at all times; writes to it and busy_set on it SHALL be ignored.
REQ-004 Reads SHALL be combinational (0-cycle latency); rdata[p]=0 when re[p]=0, raddr[p]==0, or reset=1.
REQ-005 With BYPASS=1, a read whose address matches an enabled same-cycle write (waddr!=0) SHALL return that wdata; with BYPASS=0 it SHALL return the pre-edge stored value.
REQ-006 Writes SHALL commit on the rising edge when reset=0, we[k]=1 and waddr[k]!=0.
REQ-007 When several enabled write ports target the same address in one cycle, the highest-index port SHALL win, for both the committed value and the bypass value.
REQ-008 A scoreboard of NREG busy bits SHALL be kept; busy_set sets busy[busy_addr] on the edge; any committed write to address n clears busy[n] on the edge.
REQ-009 When busy_set and a committed write target the same address in the same cycle, set SHALL win (busy stays 1).
REQ-010 rbusy[p] SHALL equal busy[raddr[p]], masked to 0 when re[p]=0, raddr[p]==0, or (BYPASS=1 and a same-cycle write hits raddr[p]).
REQ-011 pend_cnt SHALL be a registered count of set busy bits, updated every edge as +1 for a new set, -1 for each cleared bit, and unchanged for a bit that is set and cleared in the same cycle; it SHALL never wrap (maximum NREG-1).
REQ-012 idle SHALL be registered and consistent with pend_cnt in the same cycle.

Reset
REQ-013 While reset=1 at an edge, all registers SHALL become 0, all busy bits 0, pend_cnt 0 and idle 1; writes and busy_set SHALL be ignored in that cycle.
REQ-014 While reset is asserted, rdata and rbusy SHALL be 0 combinationally.
REQ-015 Reset asserted mid-operation, with writes and pending bits outstanding, SHALL discard all pending state with no partial commits.

Structure
REQ-016 A shared package regfile_pkg SHALL hold the XLEN default and NREG default, an AW-computing function, and a write-port-priority helper function.
REQ-017 Per-read-port forwarding and masking SHALL be a sub-module, regfile_bypass_mux, instantiated NRP times by generate.
REQ-018 Storage SHALL be a flip-flop array; no vendor RAM primitive SHALL be used.

Verification
REQ-019 The bench SHALL drive reset for 1 cycle and then read every address on every port; every rdata=0, rbusy=0, pend_cnt=0 and idle=1 are required.
REQ-020 The bench SHALL write 0xDEADBEEF to x5 via port0, then read x5 on the next cycle; 0xDEADBEEF is required, and a write of 0x1 to x0 SHALL read back as 0.
REQ-021 The bench SHALL drive port0 and port1 to both write x7 (0x11 and 0x22) while reading x7 in the same cycle; 0x22 is required now (BYPASS=1) and 0x22 is required afterwards.
REQ-022 The bench SHALL drive busy_set for x3, then on the next cycle read x3; rbusy=1 and pend_cnt=1 are required. The bench SHALL then write x3; rbusy=0 in that cycle and pend_cnt=0 and idle=1 on the next edge are required.
REQ-023 The bench SHALL drive busy_set for x9 and write x9 in the same cycle; afterwards busy[x9]=1 and pend_cnt unchanged+1 are required.
REQ-024 The bench SHALL set 4 busy bits and write x10=0xAA, then assert reset for 1 cycle; pend_cnt=0, x10 reading 0 and idle=1 are required.
